// File: rtl/multi_interval_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : multi_interval_timer                                           |
// | Brief   : N-channel interval timer driven by one shared prescaler tick.  |
// |           Per channel: programmable limit, one-shot/periodic mode,       |
// |           pause, clear, and done/expired/busy flags.                     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module multi_interval_timer #(
   parameter int CLK_HZ   = 50000000,
   parameter int TICK_HZ  = 2000,
   parameter int WIDTH    = 12,
   parameter int CHANNELS = 2
) (
   input  logic                      clk_50M,
   input  logic                      i_Reset_n,
   input  logic [CHANNELS-1:0]       i_Start,
   input  logic [CHANNELS-1:0]       i_Clear,
   input  logic [CHANNELS-1:0]       i_Enable,
   input  logic [CHANNELS-1:0]       i_Mode,
   input  logic [CHANNELS*WIDTH-1:0] i_Limit,
   output logic [CHANNELS*WIDTH-1:0] o_Count,
   output logic [CHANNELS-1:0]       o_Done,
   output logic [CHANNELS-1:0]       o_Expired,
   output logic [CHANNELS-1:0]       o_Busy,
   output logic                      o_Tick
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } state_t;

   logic [PW-1:0] prescaler;
   logic          tick;

   // Tick is asserted for the single cycle in which the prescaler sits at its top value.
   assign tick = (prescaler == PRE_LAST);

   // Free-running prescaler shared by all channels; o_Tick is the tick delayed one cycle.
   always_ff @(posedge clk_50M or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         prescaler <= '0;
         o_Tick    <= 1'b0;
      end else begin
         prescaler <= tick ? '0 : prescaler + PW'(1);
         o_Tick    <= tick;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      state_t             state;
      logic [WIDTH-1:0]   count;
      logic [WIDTH-1:0]   limit;
      logic [WIDTH-1:0]   last_count;
      logic               mode;
      logic               done;
      logic               busy;
      logic               expired;

      // Terminal count wraps modulo 2^WIDTH, so a limit of 0 gives a full-scale interval.
      assign last_count = limit - WIDTH'(1);

      // Channel FSM: clear beats start beats tick; flags are registered alongside the state.
      always_ff @(posedge clk_50M or negedge i_Reset_n) begin
         if (!i_Reset_n) begin
            state   <= ST_IDLE;
            count   <= '0;
            limit   <= '0;
            mode    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            expired <= 1'b0;
         end else begin
            done <= 1'b0;
            if (i_Clear[c]) begin
               state   <= ST_IDLE;
               count   <= '0;
               busy    <= 1'b0;
               expired <= 1'b0;
            end else if (i_Start[c]) begin
               state   <= ST_RUN;
               count   <= '0;
               limit   <= i_Limit[c*WIDTH +: WIDTH];
               mode    <= i_Mode[c];
               busy    <= 1'b1;
               expired <= 1'b0;
            end else if (state == ST_RUN && tick && i_Enable[c]) begin
               if (count == last_count) begin
                  done <= 1'b1;
                  if (mode) begin
                     count <= '0;
                  end else begin
                     // One-shot parks at the limit value (0 for full scale).
                     count   <= limit;
                     state   <= ST_EXPIRED;
                     busy    <= 1'b0;
                     expired <= 1'b1;
                  end
               end else begin
                  count <= count + WIDTH'(1);
               end
            end
         end
      end

      assign o_Count[c*WIDTH +: WIDTH] = count;
      assign o_Done[c]                 = done;
      assign o_Busy[c]                 = busy;
      assign o_Expired[c]              = expired;
   end

endmodule
`default_nettype wire

// File: tb/tb_multi_interval_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_multi_interval_timer                                        |
// | Brief   : Directed scoreboard bench for multi_interval_timer (DIV=10,    |
// |           WIDTH=4, 2 channels). Done pulses are matched against a queue  |
// |           of expected (cycle, count) events per channel.                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_multi_interval_timer;

   localparam int W = 4;
   localparam int N = 2;

   typedef struct {
      int cyc;
      int cnt;
   } ev_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   start = '0;
   logic [N-1:0]   clear = '0;
   logic [N-1:0]   enable = '0;
   logic [N-1:0]   mode = '0;
   logic [N*W-1:0] limit = '0;
   logic [N*W-1:0] count;
   logic [N-1:0]   done;
   logic [N-1:0]   expired;
   logic [N-1:0]   busy;
   logic           tick;

   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   ev_t q0[$];
   ev_t q1[$];

   multi_interval_timer #(
      .CLK_HZ   (10),
      .TICK_HZ  (1),
      .WIDTH    (W),
      .CHANNELS (N)
   ) dut (
      .clk_50M   (clk),
      .i_Reset_n (rst_n),
      .i_Start   (start),
      .i_Clear   (clear),
      .i_Enable  (enable),
      .i_Mode    (mode),
      .i_Limit   (limit),
      .o_Count   (count),
      .o_Done    (done),
      .o_Expired (expired),
      .o_Busy    (busy),
      .o_Tick    (tick)
   );

   always #5 clk = ~clk;

   // Cycle index: number of rising edges since reset release.
   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic int cnt(input int c);
      return int'(count[c*W +: W]);
   endfunction

   task automatic at(input int n);
      while (cyc < n) @(negedge clk);
      if (cyc != n) chk("schedule", cyc, n);
   endtask

   // Monitor: every done pulse must match the head of that channel's expectation queue.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int c = 0; c < N; c++) begin
            if (done[c]) begin
               ev_t e;
               if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
                  chk($sformatf("done_unexpected_ch%0d", c), 1, 0);
               end else begin
                  if (c == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  chk($sformatf("done_cycle_ch%0d", c), cyc, e.cyc);
                  chk($sformatf("done_count_ch%0d", c), cnt(c), e.cnt);
               end
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_count", int'(count), 0);
      chk("reset_flags", int'({done, expired, busy, tick}), 0);
      rst_n  = 1'b1;
      enable = 2'b11;

      // Prescaler: first o_Tick at cycle 10, nothing else active
      for (int k = 1; k <= 12; k++) begin
         at(k);
         chk("tick", int'(tick), (k % 10 == 0) ? 1 : 0);
         chk("idle_flags", int'({done, expired, busy}), 0);
      end

      // Ch0 one-shot, L=3
      limit[0 +: W] = 4'd3; mode[0] = 1'b0; start[0] = 1'b1;
      q0.push_back('{40, 3});
      at(13); start = '0;
      chk("os_busy", int'(busy[0]), 1);
      chk("os_cnt0", cnt(0), 0);
      at(20); chk("os_cnt1", cnt(0), 1);
      at(30); chk("os_cnt2", cnt(0), 2);
      at(40); chk("os_cnt3", cnt(0), 3);
      chk("os_expired", int'(expired[0]), 1);
      chk("os_busy_off", int'(busy[0]), 0);
      at(90); chk("os_hold_cnt", cnt(0), 3);
      chk("os_hold_exp", int'(expired[0]), 1);

      // Ch1 periodic L=2 with ch0 one-shot full scale (L=0)
      at(92);
      limit = {4'd2, 4'd0}; mode = 2'b10; start = 2'b11;
      for (int k = 0; k < 8; k++) q1.push_back('{110 + 20 * k, 0});
      q0.push_back('{250, 0});
      at(93); start = '0;
      chk("dual_busy", int'(busy), 3);
      at(100); chk("per_cnt_a", cnt(1), 1);
      at(110); chk("per_cnt_b", cnt(1), 0);
      at(120); chk("per_cnt_c", cnt(1), 1);
      at(240); chk("fs_cnt15", cnt(0), 15);
      chk("fs_busy", int'(busy[0]), 1);
      at(250); chk("fs_cnt_wrap", cnt(0), 0);
      chk("fs_expired", int'(expired[0]), 1);
      at(255); clear[1] = 1'b1;
      at(256); clear = '0;
      chk("clr_busy1", int'(busy[1]), 0);
      chk("clr_cnt1", cnt(1), 0);

      // Ch0 periodic L=5 with a pause after two ticks
      at(262);
      limit[0 +: W] = 4'd5; mode[0] = 1'b1; start[0] = 1'b1;
      q0.push_back('{340, 0});
      at(263); start = '0;
      at(270); chk("pause_cnt1", cnt(0), 1);
      at(280); chk("pause_cnt2", cnt(0), 2);
      at(282); enable[0] = 1'b0;
      at(310); chk("pause_frozen", cnt(0), 2);
      at(312); enable[0] = 1'b1;
      at(320); chk("resume_cnt3", cnt(0), 3);
      at(330); chk("resume_cnt4", cnt(0), 4);
      at(340); chk("resume_wrap", cnt(0), 0);
      chk("resume_busy", int'(busy[0]), 1);
      at(342); clear[0] = 1'b1;
      at(343); clear = '0;
      chk("clr_busy0", int'(busy[0]), 0);

      // Clear + start together, then restart mid-interval with a new limit
      at(352);
      limit[W +: W] = 4'd3; mode[1] = 1'b1; start[1] = 1'b1;
      at(353); start = '0;
      at(370); chk("cs_cnt2", cnt(1), 2);
      at(372); clear[1] = 1'b1; start[1] = 1'b1;
      at(373); clear = '0; start = '0;
      chk("cs_busy", int'(busy[1]), 0);
      chk("cs_cnt", cnt(1), 0);
      chk("cs_exp", int'(expired[1]), 0);
      at(380); chk("cs_idle_tick", cnt(1), 0);
      at(382); start[1] = 1'b1;
      at(383); start = '0;
      at(400); chk("rs_cnt2", cnt(1), 2);
      at(402);
      limit[W +: W] = 4'd2; mode[1] = 1'b0; start[1] = 1'b1;
      q1.push_back('{420, 2});
      at(403); start = '0;
      chk("rs_cnt0", cnt(1), 0);
      chk("rs_busy", int'(busy[1]), 1);
      at(405); limit[W +: W] = 4'd7; mode[1] = 1'b1;
      at(410); chk("rs_cnt1", cnt(1), 1);
      at(420); chk("rs_final", cnt(1), 2);
      chk("rs_expired", int'(expired[1]), 1);
      at(425); clear[1] = 1'b1;
      at(426); clear = '0;

      // Asynchronous reset mid-interval
      at(432);
      limit[0 +: W] = 4'd4; mode[0] = 1'b0; start[0] = 1'b1;
      at(433); start = '0;
      at(450); chk("ar_cnt2", cnt(0), 2);
      at(455);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_count", int'(count), 0);
      chk("ar_flags", int'({done, expired, busy, tick}), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      at(59); chk("ar_tick59", int'(tick), 0);
      at(60); chk("ar_tick60", int'(tick), 1);
      chk("ar_busy", int'(busy), 0);
      chk("ar_cnt", int'(count), 0);

      // Every expected done pulse must have been consumed
      chk("q0_pending", q0.size(), 0);
      chk("q1_pending", q1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
